// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C bit-level line driver.
// Command codes, phase/state encodings and the per-phase line pattern table.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } i2c_cmd_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_qtr(input int clk_mhz, input int scl_khz);
    return (clk_mhz * 1000) / (4 * scl_khz);
  endfunction

  // Returns {scl_oe, sda_oe} for a command in a given quarter; 1 = pull low.
  function automatic logic [1:0] phase_oe(input i2c_cmd_e c, input logic b,
                                          input phase_e p);
    logic [1:0] oe;
    oe = 2'b00;
    case (c)
      CMD_START: begin
        case (p)
          Q2:      oe = 2'b01;
          Q3:      oe = 2'b11;
          default: oe = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (p)
          Q0:      oe = 2'b11;
          Q1:      oe = 2'b01;
          default: oe = 2'b00;
        endcase
      end
      CMD_WRITE: oe = {(p == Q0) || (p == Q3), ~b};
      default:   oe = {(p == Q0) || (p == Q3), 1'b0};
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-period timer: ticks on the last cycle of every QTR-cycle window.
// start clears and holds the count; hold parks it at zero during clock stretch.
module i2c_qtr_timer #(
  parameter int QTR = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(QTR) + 1;
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CW'(1);
    if (start || hold) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_bit_driver.sv
// I2C controller-side bit driver: runs one START/STOP/WRITE/READ command over
// four quarter phases, with clock stretching and arbitration-loss detection.
module i2c_bit_driver
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int SCL_FREQ_KHZ = 400
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cmd_valid,
  output logic     cmd_ready,
  input  i2c_cmd_e cmd,
  input  logic     cmd_bit,
  output logic     rsp_valid,
  output logic     rsp_bit,
  output logic     busy,
  output logic     arb_lost,
  input  logic     scl_in,
  input  logic     sda_in,
  output logic     scl_oe,
  output logic     sda_oe
);

  localparam int QTR = calc_qtr(CLK_FREQ_MHZ, SCL_FREQ_KHZ);

  if (QTR < 2) begin : g_qtr_check
    $error("i2c_bit_driver: CLK_FREQ_MHZ/SCL_FREQ_KHZ give a quarter period below 2 cycles");
  end

  state_e   state_q, state_d;
  phase_e   phase_q, phase_d;
  i2c_cmd_e cmd_q, cmd_d;
  logic     bit_q, bit_d;
  logic     rsp_bit_q, rsp_bit_d;
  logic     busy_q, busy_d;
  logic     arb_q, arb_d;
  logic     scl_hold_q, scl_hold_d;
  logic     sda_hold_q, sda_hold_d;
  logic [1:0] run_oe;
  logic     accept, arb_hit, tick, timer_start, timer_hold;

  // Handshake: a command is taken on any cycle with cmd_valid && cmd_ready,
  // including the completion cycle; rsp_valid is a single-cycle pulse with
  // no back-pressure, and cmd_ready stays low for the whole run.
  assign cmd_ready   = (state_q != ST_RUN);
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_bit     = rsp_bit_q;
  assign busy        = busy_q;
  assign arb_lost    = arb_q;
  assign timer_start = (state_q != ST_RUN);
  // Stretch: SCL released by us but still seen low.
  assign timer_hold  = !run_oe[1] && !scl_in;

  // Between commands the lines keep the pattern of the last quarter driven.
  assign scl_oe = (state_q == ST_RUN) ? run_oe[1] : scl_hold_q;
  assign sda_oe = (state_q == ST_RUN) ? run_oe[0] : sda_hold_q;

  i2c_qtr_timer #(.QTR(QTR)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .hold  (timer_hold),
    .tick  (tick)
  );

  always_comb begin
    run_oe     = phase_oe(cmd_q, bit_q, phase_q);
    state_d    = state_q;
    phase_d    = phase_q;
    cmd_d      = cmd_q;
    bit_d      = bit_q;
    rsp_bit_d  = rsp_bit_q;
    busy_d     = busy_q;
    arb_d      = arb_q;
    scl_hold_d = scl_hold_q;
    sda_hold_d = sda_hold_q;
    accept     = cmd_valid && cmd_ready;
    arb_hit    = (state_q == ST_RUN) && (cmd_q == CMD_WRITE) && bit_q &&
                 ((phase_q == Q1) || (phase_q == Q2)) && scl_in && !sda_in;

    case (state_q)
      ST_RUN: begin
        scl_hold_d = run_oe[1];
        sda_hold_d = run_oe[0];
        if (arb_hit) begin
          state_d    = ST_DONE;
          arb_d      = 1'b1;
          busy_d     = 1'b0;
          rsp_bit_d  = 1'b0;
          scl_hold_d = 1'b0;
          sda_hold_d = 1'b0;
        end else if (tick) begin
          if (phase_q == Q2) begin
            rsp_bit_d = sda_in;
          end
          if (phase_q == Q3) begin
            state_d = ST_DONE;
            if (cmd_q == CMD_START) begin
              busy_d    = 1'b1;
              rsp_bit_d = 1'b0;
            end else if (cmd_q == CMD_STOP) begin
              busy_d    = 1'b0;
              rsp_bit_d = 1'b0;
            end
          end else begin
            phase_d = phase_e'(phase_q + 2'd1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          cmd_d   = cmd;
          bit_d   = cmd_bit;
          phase_d = Q0;
          if (cmd == CMD_START) begin
            arb_d   = 1'b0;
            state_d = ST_RUN;
          end else if (arb_q) begin
            // Bus lost: complete at once without touching the lines.
            state_d   = ST_DONE;
            rsp_bit_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= Q0;
      cmd_q      <= CMD_START;
      bit_q      <= 1'b0;
      rsp_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      arb_q      <= 1'b0;
      scl_hold_q <= 1'b0;
      sda_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cmd_q      <= cmd_d;
      bit_q      <= bit_d;
      rsp_bit_q  <= rsp_bit_d;
      busy_q     <= busy_d;
      arb_q      <= arb_d;
      scl_hold_q <= scl_hold_d;
      sda_hold_q <= sda_hold_d;
    end
  end

endmodule

// File: tb/tb_i2c_bit_driver.sv
// Bench for i2c_bit_driver with wired-AND SCL/SDA, a stretching/driving target,
// a directed vector table, hand sequences and a randomized reference model.
module tb_i2c_bit_driver;
  import i2c_pkg::*;

  localparam int QTR = 5;

  logic     clk = 1'b0;
  logic     rst;
  logic     cmd_valid;
  logic     cmd_ready;
  i2c_cmd_e cmd;
  logic     cmd_bit;
  logic     rsp_valid;
  logic     rsp_bit;
  logic     busy;
  logic     arb_lost;
  logic     scl_in, sda_in, scl_oe, sda_oe;
  logic     scl_stretch, sda_tgt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign scl_in = ~scl_oe & ~scl_stretch;
  assign sda_in = ~sda_oe & ~sda_tgt;

  i2c_bit_driver #(.CLK_FREQ_MHZ(100), .SCL_FREQ_KHZ(5000)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_bit(cmd_bit), .rsp_valid(rsp_valid), .rsp_bit(rsp_bit),
    .busy(busy), .arb_lost(arb_lost), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor: SDA may only move with SCL released during START/STOP.
  i2c_cmd_e cur_cmd = CMD_START;
  logic     mon_en = 1'b0;
  logic     prev_scl = 1'b0, prev_sda = 1'b0;
  int       viol = 0;

  always @(negedge clk) begin
    if (mon_en && !rst && !prev_scl && !scl_oe && (sda_oe !== prev_sda) &&
        cur_cmd != CMD_START && cur_cmd != CMD_STOP)
      viol <= viol + 1;
    prev_scl <= scl_oe;
    prev_sda <= sda_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver task: issues one command, then plays the target side until rsp.
  task automatic run_cmd(input i2c_cmd_e c, input logic b, input logic tgt,
                         input int st_len, output int lat, output logic rbit,
                         output logic got);
    int n, k, guard;
    got = 1'b0; lat = 0; rbit = 1'b0; guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    cur_cmd   = c;
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_bit   = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd       = i2c_cmd_e'($urandom_range(0, 3));
    cmd_bit   = 1'($urandom_range(0, 1));
    n = cyc - 1;
    for (int i = 0; i < 300 && !got; i++) begin
      k = cyc - n;
      scl_stretch = (st_len > 0) && (k >= QTR + 1) && (k < QTR + 1 + st_len);
      sda_tgt     = tgt && (k >= QTR + 1);
      if (rsp_valid) begin
        got = 1'b1; lat = k; rbit = rsp_bit;
      end else begin
        @(posedge clk); #1;
      end
    end
    scl_stretch = 1'b0;
    sda_tgt     = 1'b0;
  endtask

  typedef struct {
    i2c_cmd_e c;
    logic     b;
    logic     tgt;
    int       st;
    int       lat;
    logic     rbit;
    logic     busy;
    logic     arb;
    logic     scl;
    logic     sda;
  } vec_t;

  vec_t vecs[12];

  // Scoreboard of expected responses for the randomized phase.
  logic [31:0] exp_q[$];

  initial begin
    int       lat, k, n, pulses;
    logic     rbit, got;
    logic     m_busy, m_arb, tgt, b;
    int       st, e_lat;
    logic     e_rbit;
    i2c_cmd_e c;

    vecs[0]  = '{CMD_START, 1'b0, 1'b0, 0,  21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{CMD_WRITE, 1'b1, 1'b0, 0,  21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{CMD_WRITE, 1'b0, 1'b0, 0,  21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{CMD_STOP,  1'b0, 1'b0, 0,  21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{CMD_START, 1'b0, 1'b0, 0,  21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{CMD_READ,  1'b0, 1'b1, 0,  21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{CMD_READ,  1'b0, 1'b0, 0,  21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{CMD_WRITE, 1'b1, 1'b0, 30, 51, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{CMD_WRITE, 1'b1, 1'b1, 0,  7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{CMD_WRITE, 1'b0, 1'b0, 0,  1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{CMD_START, 1'b0, 1'b0, 0,  21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{CMD_STOP,  1'b0, 1'b0, 0,  21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd = CMD_START; cmd_bit = 1'b0;
    scl_stretch = 1'b0; sda_tgt = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl_oe", scl_oe, 0);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_arb_lost", arb_lost, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].c, vecs[i].b, vecs[i].tgt, vecs[i].st, lat, rbit, got);
      check($sformatf("vec%0d_rsp_seen", i), got, 1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_rsp_bit", i), rbit, vecs[i].rbit);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_arb_lost", i), arb_lost, vecs[i].arb);
      check($sformatf("vec%0d_cmd_ready", i), cmd_ready, 1);
      check($sformatf("vec%0d_scl_oe", i), scl_oe, vecs[i].scl);
      check($sformatf("vec%0d_sda_oe", i), sda_oe, vecs[i].sda);
      check($sformatf("vec%0d_line_protocol", i), viol, 0);
    end

    // rsp_valid must be a single-cycle pulse
    @(posedge clk); #1;
    check("rsp_pulse_width", rsp_valid, 0);

    // Mid-command reset during Q2 of WRITE 0
    mon_en    = 1'b0;
    cur_cmd   = CMD_WRITE;
    cmd_valid = 1'b1; cmd = CMD_WRITE; cmd_bit = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = cyc - 1;
    repeat (2 * QTR) @(posedge clk);
    #1;
    k = cyc - n;
    check("midrst_in_q2", k, 2 * QTR + 1);
    check("midrst_q2_scl_oe", scl_oe, 0);
    check("midrst_q2_sda_oe", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_scl_oe", scl_oe, 0);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    check("midrst_no_rsp", pulses, 0);
    check("midrst_idle_ready", cmd_ready, 1);

    // Randomized commands against a behavioural model
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    m_busy = 1'b0;
    m_arb  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      c   = i2c_cmd_e'($urandom_range(0, 3));
      b   = 1'($urandom_range(0, 1));
      tgt = (c == CMD_WRITE || c == CMD_READ) ? 1'($urandom_range(0, 1)) : 1'b0;
      st  = (c != CMD_START && $urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      // Model: 4 quarters plus one completion cycle plus any stretch.
      if (m_arb && c != CMD_START) begin
        e_lat = 1; e_rbit = 1'b1;
      end else if (c == CMD_START) begin
        e_lat = 4 * QTR + 1; e_rbit = 1'b0; m_busy = 1'b1; m_arb = 1'b0;
      end else if (c == CMD_STOP) begin
        e_lat = 4 * QTR + 1 + st; e_rbit = 1'b0; m_busy = 1'b0;
      end else if (c == CMD_WRITE && b && tgt) begin
        e_lat = QTR + 2 + st; e_rbit = 1'b0; m_busy = 1'b0; m_arb = 1'b1;
      end else if (c == CMD_WRITE) begin
        e_lat = 4 * QTR + 1 + st; e_rbit = b & ~tgt;
      end else begin
        e_lat = 4 * QTR + 1 + st; e_rbit = ~tgt;
      end
      exp_q.push_back({e_lat[29:0], e_rbit, 1'b0});
      run_cmd(c, b, tgt, st, lat, rbit, got);
      check($sformatf("rnd%0d_rsp_seen", i), got, 1);
      check($sformatf("rnd%0d_lat_bit", i), {lat[29:0], rbit, 1'b0}, exp_q.pop_front());
      check($sformatf("rnd%0d_busy", i), busy, m_busy);
      check($sformatf("rnd%0d_arb_lost", i), arb_lost, m_arb);
      check($sformatf("rnd%0d_line_protocol", i), viol, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
